// File: rtl/ip_stack_pkg.sv
// Shared definitions for the IP stack ingress/egress stream blocks.
// Control-word layout helpers and receive packet-state encodings.
package ip_stack_pkg;

    localparam int AXIS_DATA_WIDTH = 128;
    localparam int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8;

    // Control word is {valid, last, keep[KEEP_WIDTH-1:0]}
    localparam int CTRL_VALID_BIT = AXIS_KEEP_WIDTH + 1;
    localparam int CTRL_LAST_BIT  = AXIS_KEEP_WIDTH;

    typedef enum logic [7:0] {
        AXIS_RX_IDLE    = 8'h01,
        AXIS_RX_ACTIVE  = 8'h02,
        AXIS_RX_DISCARD = 8'h04
    } axis_rx_state_e;

    function automatic int ctrl_valid_bit(input int keep_width);
        return keep_width + 1;
    endfunction

    function automatic int ctrl_last_bit(input int keep_width);
        return keep_width;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer with a registered ready.
// Ready depends only on occupancy, so it never combinationally follows the sink.
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push        = in_valid_i && ready_q;
    assign pop         = (count_q != 2'd0) && out_ready_i;
    assign in_ready_o  = ready_q;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and registered ready
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
            ready_q <= (count_d < 2'd2);
        end
    end

endmodule

// File: rtl/axis_to_fifo.sv
// AXI-Stream receive side: filters null beats, bounds packet length
// and writes beats into the paired data/control FIFOs.
module axis_to_fifo
    import ip_stack_pkg::*;
#(
    parameter  int DATA_WIDTH = 128,
    parameter  int MAX_BEATS  = 64,
    localparam int KEEP_WIDTH = DATA_WIDTH / 8,
    localparam int CTRL_WIDTH = KEEP_WIDTH + 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  data_fifo_full,
    input  logic                  control_fifo_full,
    output logic                  fifo_write_enable,
    output logic [DATA_WIDTH-1:0] fifo_data_in,
    output logic [CTRL_WIDTH-1:0] fifo_control_in,
    output logic [15:0]           packet_count,
    output logic                  overrun
);

    localparam int IDX_W   = $clog2(MAX_BEATS);
    localparam int VLD_BIT = ctrl_valid_bit(KEEP_WIDTH);
    localparam int LST_BIT = ctrl_last_bit(KEEP_WIDTH);
    localparam int PAY_W   = CTRL_WIDTH + DATA_WIDTH;

    axis_rx_state_e   state_q;
    axis_rx_state_e   state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             overrun_q;
    logic             overrun_d;
    logic [15:0]      pkt_q;
    logic [15:0]      pkt_d;

    logic                  skid_ready;
    logic                  skid_valid;
    logic                  accept;
    logic                  null_beat;
    logic                  store_beat;
    logic                  at_limit;
    logic                  truncate;
    logic                  last_eff;
    logic                  sink_ready;
    logic [CTRL_WIDTH-1:0] ctrl_word;
    logic [PAY_W-1:0]      head;

    assign accept     = s_axis_tvalid && skid_ready;
    assign null_beat  = (s_axis_tkeep == '0) && !s_axis_tlast;
    assign store_beat = (state_q != AXIS_RX_DISCARD) && !null_beat;
    assign at_limit   = (state_q == AXIS_RX_ACTIVE)
                     && (idx_q == IDX_W'(MAX_BEATS - 1));
    assign truncate   = store_beat && at_limit && !s_axis_tlast;
    assign last_eff   = s_axis_tlast || truncate;
    assign sink_ready = !data_fifo_full && !control_fifo_full;

    // Control word for the incoming beat; last is forced on truncation
    always_comb begin
        ctrl_word                   = '0;
        ctrl_word[VLD_BIT]          = 1'b1;
        ctrl_word[LST_BIT]          = last_eff;
        ctrl_word[KEEP_WIDTH-1:0]   = s_axis_tkeep;
    end

    axis_skid_buffer #(
        .WIDTH (PAY_W)
    ) u_skid (
        .clock       (clock),
        .reset       (reset),
        .in_valid_i  (s_axis_tvalid && store_beat),
        .in_ready_o  (skid_ready),
        .in_data_i   ({ctrl_word, s_axis_tdata}),
        .out_valid_o (skid_valid),
        .out_ready_i (sink_ready),
        .out_data_o  (head)
    );

    assign fifo_write_enable = skid_valid && sink_ready;
    assign fifo_data_in      = head[DATA_WIDTH-1:0];
    assign fifo_control_in   = head[PAY_W-1 -: CTRL_WIDTH];
    assign s_axis_tready     = skid_ready;
    assign packet_count      = pkt_q;
    assign overrun           = overrun_q;

    // Packet state, beat index, overrun pulse and packet counter
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = 1'b0;
        pkt_d     = pkt_q;
        if (fifo_write_enable && fifo_control_in[LST_BIT]) begin
            pkt_d = pkt_q + 16'd1;
        end
        if (accept) begin
            unique case (state_q)
                AXIS_RX_IDLE: begin
                    if (store_beat && !s_axis_tlast) begin
                        state_d = AXIS_RX_ACTIVE;
                        idx_d   = IDX_W'(1);
                    end
                end
                AXIS_RX_ACTIVE: begin
                    if (store_beat) begin
                        if (s_axis_tlast) begin
                            state_d = AXIS_RX_IDLE;
                            idx_d   = '0;
                        end else if (truncate) begin
                            state_d   = AXIS_RX_DISCARD;
                            idx_d     = '0;
                            overrun_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                AXIS_RX_DISCARD: begin
                    if (s_axis_tlast) begin
                        state_d = AXIS_RX_IDLE;
                    end
                end
                default: begin
                    state_d = AXIS_RX_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // State registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= AXIS_RX_IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            pkt_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            pkt_q     <= pkt_d;
        end
    end

endmodule

// File: tb/tb_axis_to_fifo.sv
// Directed bench for axis_to_fifo: one default instance and one
// instance with MAX_BEATS=4 for the truncation scenario.
module tb_axis_to_fifo;

    localparam int DW = 128;
    localparam int KW = 16;
    localparam int CW = 18;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          tvalid = 1'b0;
    logic [DW-1:0] tdata = '0;
    logic          tlast = 1'b0;
    logic [KW-1:0] tkeep = '0;
    logic          dfull = 1'b0;
    logic          cfull = 1'b0;

    logic          rdy_a, wen_a, ovr_a;
    logic [DW-1:0] dat_a;
    logic [CW-1:0] ctl_a;
    logic [15:0]   pc_a;
    logic          rdy_b, wen_b, ovr_b;
    logic [DW-1:0] dat_b;
    logic [CW-1:0] ctl_b;
    logic [15:0]   pc_b;

    int cmp = 0;
    int fail = 0;
    int cyc = 0;
    bit cap = 1'b1;
    int ovr_cnt_b = 0;
    logic [CW+DW-1:0] wq_a[$];
    logic [CW+DW-1:0] wq_b[$];
    int               wc_a[$];

    always #5 clock = ~clock;

    axis_to_fifo dut_a (
        .clock             (clock),
        .reset             (reset),
        .s_axis_tvalid     (tvalid),
        .s_axis_tready     (rdy_a),
        .s_axis_tdata      (tdata),
        .s_axis_tlast      (tlast),
        .s_axis_tkeep      (tkeep),
        .data_fifo_full    (dfull),
        .control_fifo_full (cfull),
        .fifo_write_enable (wen_a),
        .fifo_data_in      (dat_a),
        .fifo_control_in   (ctl_a),
        .packet_count      (pc_a),
        .overrun           (ovr_a)
    );

    axis_to_fifo #(.MAX_BEATS(4)) dut_b (
        .clock             (clock),
        .reset             (reset),
        .s_axis_tvalid     (tvalid),
        .s_axis_tready     (rdy_b),
        .s_axis_tdata      (tdata),
        .s_axis_tlast      (tlast),
        .s_axis_tkeep      (tkeep),
        .data_fifo_full    (dfull),
        .control_fifo_full (cfull),
        .fifo_write_enable (wen_b),
        .fifo_data_in      (dat_b),
        .fifo_control_in   (ctl_b),
        .packet_count      (pc_b),
        .overrun           (ovr_b)
    );

    always @(posedge clock) cyc <= cyc + 1;

    // Write-port monitor: a strobe seen at negedge is written at the next edge
    always @(negedge clock) begin
        if (cap) begin
            if (wen_a) begin
                wq_a.push_back({ctl_a, dat_a});
                wc_a.push_back(cyc);
            end
            if (wen_b) wq_b.push_back({ctl_b, dat_b});
            if (ovr_b) ovr_cnt_b++;
        end
    end

    function automatic logic [31:0] lfsr(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    function automatic logic [DW-1:0] pat(input logic [31:0] tag, input int i);
        return {4{tag + 32'(i)}};
    endfunction

    task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k,
                        input logic l, input bit use_b);
        bit rdy;
        bit done;
        done = 1'b0;
        tvalid = 1'b1;
        tdata = d;
        tkeep = k;
        tlast = l;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clock);
            rdy = use_b ? rdy_b : rdy_a;
            @(posedge clock);
            #1;
            done = rdy;
        end
        if (!done) begin
            cmp++; fail++;
            $display("FAIL send_timeout: beat %h not accepted in 50 cycles", d);
        end
    endtask

    task automatic idle(input int n);
        tvalid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tvalid = 1'b0;
        dfull = 1'b0;
        cfull = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        @(posedge clock);
        #1;
        wq_a.delete();
        wc_a.delete();
        wq_b.delete();
        ovr_cnt_b = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tvalid = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        cmp++; if (rdy_a !== 1'b0) begin fail++; $display("FAIL rst_tready: got %b want 0", rdy_a); end
        cmp++; if (wen_a !== 1'b0) begin fail++; $display("FAIL rst_wen: got %b want 0", wen_a); end
        cmp++; if (dat_a !== '0) begin fail++; $display("FAIL rst_data: got %h want 0", dat_a); end
        cmp++; if (ctl_a !== '0) begin fail++; $display("FAIL rst_ctrl: got %h want 0", ctl_a); end
        cmp++; if (pc_a !== 16'd0) begin fail++; $display("FAIL rst_pcount: got %h want 0", pc_a); end
        cmp++; if (ovr_a !== 1'b0) begin fail++; $display("FAIL rst_overrun: got %b want 0", ovr_a); end
        cmp++; if (rdy_b !== 1'b0) begin fail++; $display("FAIL rst_tready_b: got %b want 0", rdy_b); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        cmp++; if (rdy_a !== 1'b0) begin fail++; $display("FAIL rel_tready_early: got %b want 0", rdy_a); end
        @(posedge clock);
        #1;
        @(negedge clock);
        cmp++; if (rdy_a !== 1'b1) begin fail++; $display("FAIL rel_tready: got %b want 1", rdy_a); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_streaming();
        logic [DW-1:0] sd [5];
        logic [31:0]   s;
        logic [CW-1:0] ec;
        int            first;
        int            n;
        s = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            for (int w = 0; w < 4; w++) begin
                s = lfsr(s);
                sd[i][w*32 +: 32] = s;
            end
        end
        do_reset();
        first = 0;
        for (int i = 0; i < 5; i++) begin
            send(sd[i], 16'hFFFF, i == 4, 1'b0);
            if (i == 0) first = cyc;
        end
        idle(3);
        cmp++; if (wq_a.size() !== 5) begin fail++; $display("FAIL stream_nwrites: got %0d want 5", wq_a.size()); end
        n = (wq_a.size() < 5) ? wq_a.size() : 5;
        for (int i = 0; i < n; i++) begin
            ec = (i == 4) ? 18'h3FFFF : 18'h2FFFF;
            cmp++;
            if (wq_a[i] !== {ec, sd[i]}) begin
                fail++; $display("FAIL stream_word[%0d]: got %h want %h", i, wq_a[i], {ec, sd[i]});
            end
            cmp++;
            if (wc_a[i] !== first + i) begin
                fail++; $display("FAIL stream_cycle[%0d]: got %0d want %0d", i, wc_a[i], first + i);
            end
        end
        cmp++; if (pc_a !== 16'd1) begin fail++; $display("FAIL stream_pcount: got %0d want 1", pc_a); end
    endtask

    task automatic test_backpressure();
        int nxt;
        int low_at;
        int wr_full;
        int n;
        bit rdy;
        logic [CW-1:0] ec;
        do_reset();
        for (int i = 0; i < 3; i++) send(pat(32'hB00D0000, i), 16'hFFFF, 1'b0, 1'b0);
        dfull = 1'b1;
        nxt = 3;
        low_at = -1;
        wr_full = 0;
        for (int c = 0; c < 10; c++) begin
            tvalid = 1'b1;
            tdata = pat(32'hB00D0000, nxt);
            tkeep = 16'hFFFF;
            tlast = (nxt == 7);
            @(negedge clock);
            rdy = rdy_a;
            if (!rdy && low_at < 0) low_at = c;
            if (wen_a) wr_full++;
            @(posedge clock);
            #1;
            if (rdy) nxt++;
        end
        cmp++; if (!(low_at >= 0 && low_at <= 2)) begin fail++; $display("FAIL bp_tready_drop: got cycle %0d want 0..2", low_at); end
        cmp++; if (wr_full !== 0) begin fail++; $display("FAIL bp_write_while_full: got %0d want 0", wr_full); end
        cmp++; if (nxt !== 4) begin fail++; $display("FAIL bp_accepted_while_full: got %0d want 4", nxt); end
        dfull = 1'b0;
        tvalid = 1'b0;
        @(negedge clock);
        cmp++; if (wen_a !== 1'b1) begin fail++; $display("FAIL bp_resume_wen: got %b want 1", wen_a); end
        cmp++; if (rdy_a !== 1'b0) begin fail++; $display("FAIL bp_resume_tready0: got %b want 0", rdy_a); end
        @(posedge clock);
        #1;
        @(negedge clock);
        cmp++; if (rdy_a !== 1'b1) begin fail++; $display("FAIL bp_resume_tready1: got %b want 1", rdy_a); end
        @(posedge clock);
        #1;
        for (int i = nxt; i < 8; i++) send(pat(32'hB00D0000, i), 16'hFFFF, i == 7, 1'b0);
        idle(3);
        cmp++; if (wq_a.size() !== 8) begin fail++; $display("FAIL bp_nwrites: got %0d want 8", wq_a.size()); end
        n = (wq_a.size() < 8) ? wq_a.size() : 8;
        for (int i = 0; i < n; i++) begin
            ec = (i == 7) ? 18'h3FFFF : 18'h2FFFF;
            cmp++;
            if (wq_a[i] !== {ec, pat(32'hB00D0000, i)}) begin
                fail++; $display("FAIL bp_word[%0d]: got %h want %h", i, wq_a[i], {ec, pat(32'hB00D0000, i)});
            end
        end
        cmp++; if (pc_a !== 16'd1) begin fail++; $display("FAIL bp_pcount: got %0d want 1", pc_a); end
    endtask

    task automatic test_null_beats();
        logic [KW-1:0] kv [8];
        logic [CW+DW-1:0] ew [4];
        int n;
        kv = '{16'h0000, 16'h00FF, 16'h0000, 16'h0000,
               16'hFFFF, 16'h0000, 16'h0001, 16'h0000};
        ew[0] = {18'h200FF, pat(32'hA0000000, 1)};
        ew[1] = {18'h2FFFF, pat(32'hA0000000, 4)};
        ew[2] = {18'h20001, pat(32'hA0000000, 6)};
        ew[3] = {18'h30000, pat(32'hA0000000, 7)};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(pat(32'hA0000000, i), kv[i], i == 7, 1'b0);
            if (i == 1) begin
                tvalid = 1'b0;
                cfull = 1'b1;
                @(negedge clock);
                cmp++; if (wen_a !== 1'b0) begin fail++; $display("FAIL null_ctrl_full_wen: got %b want 0", wen_a); end
                @(posedge clock);
                #1;
                cfull = 1'b0;
            end
        end
        idle(3);
        cmp++; if (wq_a.size() !== 4) begin fail++; $display("FAIL null_nwrites: got %0d want 4", wq_a.size()); end
        n = (wq_a.size() < 4) ? wq_a.size() : 4;
        for (int i = 0; i < n; i++) begin
            cmp++;
            if (wq_a[i] !== ew[i]) begin
                fail++; $display("FAIL null_word[%0d]: got %h want %h", i, wq_a[i], ew[i]);
            end
        end
        cmp++; if (pc_a !== 16'd1) begin fail++; $display("FAIL null_pcount: got %0d want 1", pc_a); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [CW-1:0] ec;
        for (int i = 0; i < 2; i++) send(pat(32'hC0DE0000, i), 16'hFFFF, 1'b0, 1'b0);
        reset = 1'b1;
        tvalid = 1'b0;
        @(posedge clock);
        #1;
        @(negedge clock);
        cmp++; if (rdy_a !== 1'b0) begin fail++; $display("FAIL mid_tready: got %b want 0", rdy_a); end
        cmp++; if (wen_a !== 1'b0) begin fail++; $display("FAIL mid_wen: got %b want 0", wen_a); end
        cmp++; if (dat_a !== '0) begin fail++; $display("FAIL mid_data: got %h want 0", dat_a); end
        cmp++; if (ctl_a !== '0) begin fail++; $display("FAIL mid_ctrl: got %h want 0", ctl_a); end
        cmp++; if (pc_a !== 16'd0) begin fail++; $display("FAIL mid_pcount: got %0d want 0", pc_a); end
        cmp++; if (ovr_a !== 1'b0) begin fail++; $display("FAIL mid_overrun: got %b want 0", ovr_a); end
        @(posedge clock);
        #1;
        @(negedge clock);
        cmp++; if (rdy_a !== 1'b0) begin fail++; $display("FAIL mid_tready_hold: got %b want 0", rdy_a); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        wq_a.delete();
        wc_a.delete();
        for (int i = 0; i < 5; i++) send(pat(32'hD0000000, i), 16'hFFFF, i == 4, 1'b0);
        idle(3);
        cmp++; if (wq_a.size() !== 5) begin fail++; $display("FAIL mid_nwrites: got %0d want 5", wq_a.size()); end
        n = (wq_a.size() < 5) ? wq_a.size() : 5;
        for (int i = 0; i < n; i++) begin
            ec = (i == 4) ? 18'h3FFFF : 18'h2FFFF;
            cmp++;
            if (wq_a[i] !== {ec, pat(32'hD0000000, i)}) begin
                fail++; $display("FAIL mid_word[%0d]: got %h want %h", i, wq_a[i], {ec, pat(32'hD0000000, i)});
            end
        end
        cmp++; if (pc_a !== 16'd1) begin fail++; $display("FAIL mid_pcount_after: got %0d want 1", pc_a); end
    endtask

    task automatic test_truncation();
        logic [CW+DW-1:0] ew [6];
        int n;
        for (int i = 0; i < 3; i++) ew[i] = {18'h2FFFF, pat(32'hE0000000, i)};
        ew[3] = {18'h3FFFF, pat(32'hE0000000, 3)};
        ew[4] = {18'h2FFFF, pat(32'hF0000000, 0)};
        ew[5] = {18'h3FFFF, pat(32'hF0000000, 1)};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send(pat(32'hE0000000, i), 16'hFFFF, i == 6, 1'b1);
            if (i == 3) begin
                cmp++; if (ovr_b !== 1'b1) begin fail++; $display("FAIL trunc_overrun_hi: got %b want 1", ovr_b); end
            end
            if (i == 4) begin
                cmp++; if (ovr_b !== 1'b0) begin fail++; $display("FAIL trunc_overrun_lo: got %b want 0", ovr_b); end
            end
        end
        for (int i = 0; i < 2; i++) send(pat(32'hF0000000, i), 16'hFFFF, i == 1, 1'b1);
        idle(3);
        cmp++; if (wq_b.size() !== 6) begin fail++; $display("FAIL trunc_nwrites: got %0d want 6", wq_b.size()); end
        n = (wq_b.size() < 6) ? wq_b.size() : 6;
        for (int i = 0; i < n; i++) begin
            cmp++;
            if (wq_b[i] !== ew[i]) begin
                fail++; $display("FAIL trunc_word[%0d]: got %h want %h", i, wq_b[i], ew[i]);
            end
        end
        cmp++; if (ovr_cnt_b !== 1) begin fail++; $display("FAIL trunc_overrun_count: got %0d want 1", ovr_cnt_b); end
        cmp++; if (pc_b !== 16'd2) begin fail++; $display("FAIL trunc_pcount: got %0d want 2", pc_b); end
    endtask

    task automatic test_wrap();
        int n;
        bit rdy;
        do_reset();
        cap = 1'b0;
        tvalid = 1'b1;
        tdata = pat(32'h5A5A0000, 0);
        tkeep = 16'hFFFF;
        tlast = 1'b1;
        n = 0;
        for (int t = 0; t < 70000 && n < 65535; t++) begin
            @(negedge clock);
            rdy = rdy_a;
            @(posedge clock);
            #1;
            if (rdy) n++;
        end
        idle(3);
        cmp++; if (n !== 65535) begin fail++; $display("FAIL wrap_accepts: got %0d want 65535", n); end
        cmp++; if (pc_a !== 16'hFFFF) begin fail++; $display("FAIL wrap_pcount_max: got %h want ffff", pc_a); end
        send(pat(32'h5A5A0000, 1), 16'hFFFF, 1'b1, 1'b0);
        idle(3);
        cmp++; if (pc_a !== 16'h0000) begin fail++; $display("FAIL wrap_pcount_zero: got %h want 0000", pc_a); end
        cap = 1'b1;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_null_beats();
        test_reset_mid();
        test_truncation();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fail);
        $finish;
    end

endmodule
